// File: rtl/decoder3_to_8_if.sv
`default_nettype none
// ============================================================================
// Module      : decoder3_to_8_if
// Description : Bundle of the select/enable inputs and the decoded outputs of
//               the registered 3-to-8 decoder.
//                 en      - decode enable (master -> slave)
//                 a, b, c - select bits, a = MSB (master -> slave)
//                 out     - 8-bit one-hot decoded code (slave -> master)
//                 out_vld - out holds a decoded value (slave -> master)
//               The master modport drives the selects; the slave modport is
//               the decoder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface decoder3_to_8_if;
    logic       en;
    logic       a;
    logic       b;
    logic       c;
    logic [7:0] out;
    logic       out_vld;

    modport master (
        output en,
        output a,
        output b,
        output c,
        input  out,
        input  out_vld
    );

    modport slave (
        input  en,
        input  a,
        input  b,
        input  c,
        output out,
        output out_vld
    );
endinterface : decoder3_to_8_if
`default_nettype wire

// File: rtl/decoder3_to_8.sv
`default_nettype none
// ============================================================================
// Module      : decoder3_to_8
// Description : Registered 3-to-8 line decoder. The select index {a,b,c}
//               (a = MSB) is decoded to a one-hot code that appears on out one
//               sys_clk edge after it is sampled. With en low the output
//               returns to the idle value and out_vld drops. There is no
//               combinational path from any input to any output.
// Ports       : sys_clk   - system clock, rising-edge active
//               sys_rst_n - asynchronous assert, active-low reset
//               bus       - decoder3_to_8_if.slave (en, a, b, c, out, out_vld)
// Parameters  : IDLE_OUT  - code driven (before polarity) at reset / en=0
// Build macro : DECODER3_TO_8_ACTIVE_LOW_EN - when defined, out is driven
//               inverted (selected line low, idle value ~IDLE_OUT); out_vld
//               keeps its active-high meaning.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder3_to_8 #(
    parameter logic [7:0] IDLE_OUT = 8'h00
) (
    input  wire logic        sys_clk,
    input  wire logic        sys_rst_n,
    decoder3_to_8_if.slave   bus
);

    // Idle/reset pattern as it appears on the pins, polarity already applied.
`ifdef DECODER3_TO_8_ACTIVE_LOW_EN
    localparam logic [7:0] c_idle_pin = ~IDLE_OUT;
`else
    localparam logic [7:0] c_idle_pin = IDLE_OUT;
`endif

    logic [2:0] w_sel;
    logic [7:0] w_code;
    logic [7:0] w_out_d;
    logic       w_out_vld_d;
    logic [7:0] r_out_q;
    logic       r_out_vld_q;

    always_comb begin
        w_sel       = {bus.a, bus.b, bus.c};
        w_code      = 8'h01 << w_sel;
        w_out_d     = c_idle_pin;
        w_out_vld_d = 1'b0;
        if (bus.en) begin
`ifdef DECODER3_TO_8_ACTIVE_LOW_EN
            w_out_d = ~w_code;
`else
            w_out_d = w_code;
`endif
            w_out_vld_d = 1'b1;
        end
    end

    // Reset forces the idle pattern immediately, independent of the clock;
    // release is picked up on the next rising edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_out_q     <= c_idle_pin;
            r_out_vld_q <= 1'b0;
        end else begin
            r_out_q     <= w_out_d;
            r_out_vld_q <= w_out_vld_d;
        end
    end

    assign bus.out     = r_out_q;
    assign bus.out_vld = r_out_vld_q;

endmodule : decoder3_to_8
`default_nettype wire

// File: tb/tb_decoder3_to_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder3_to_8
// Description : Self-checking bench for decoder3_to_8. Directed vectors from a
//               table, hand-written reset/latency/enable sequences, then
//               random selects compared against an arithmetic reference model.
//               Expected pin values follow DECODER3_TO_8_ACTIVE_LOW_EN when
//               the bench is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder3_to_8;

    localparam logic [7:0] c_idle = 8'h00;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    decoder3_to_8_if bus ();

    decoder3_to_8 #(
        .IDLE_OUT (c_idle)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] sel;
        logic [7:0] exp_out;   // active-high form
        logic       exp_vld;
    } vec_t;

    vec_t vecs [10];

    // Convert an active-high code to what the pins should show.
    function automatic logic [7:0] pin(input logic [7:0] code);
`ifdef DECODER3_TO_8_ACTIVE_LOW_EN
        return ~code;
`else
        return code;
`endif
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: out=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: out_vld=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic en, input logic [2:0] sel);
        @(negedge clk);
        bus.en = en;
        {bus.a, bus.b, bus.c} = sel;
        if (en && $isunknown({bus.a, bus.b, bus.c})) begin
            failures++;
            $display("FAIL x_on_select: sel=%b while en=1", {bus.a, bus.b, bus.c});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_code;
        logic       r_en;
        logic [2:0] r_sel;

        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b1, 3'b000, 8'h01, 1'b1};
        vecs[1] = '{1'b1, 3'b001, 8'h02, 1'b1};
        vecs[2] = '{1'b1, 3'b010, 8'h04, 1'b1};
        vecs[3] = '{1'b1, 3'b100, 8'h10, 1'b1};
        vecs[4] = '{1'b1, 3'b011, 8'h08, 1'b1};
        vecs[5] = '{1'b1, 3'b101, 8'h20, 1'b1};
        vecs[6] = '{1'b1, 3'b110, 8'h40, 1'b1};
        vecs[7] = '{1'b1, 3'b111, 8'h80, 1'b1};
        vecs[8] = '{1'b0, 3'b011, 8'h00, 1'b0};
        vecs[9] = '{1'b1, 3'b011, 8'h08, 1'b1};

        // Reset held with en=1, sel=101: edges must not change anything.
        rst_n = 1'b0;
        bus.en = 1'b1;
        {bus.a, bus.b, bus.c} = 3'b101;
        repeat (3) @(posedge clk);
        #1;
        check8("reset_out", bus.out, pin(c_idle));
        check1("reset_vld", bus.out_vld, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check8("release_out", bus.out, pin(8'h20));
        check1("release_vld", bus.out_vld, 1'b1);

        // Table sweep, each vector held 20 cycles (200 ns) to show it is stable.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].en, vecs[i].sel);
            check8($sformatf("vec%0d_out", i), bus.out, pin(vecs[i].exp_out));
            check1($sformatf("vec%0d_vld", i), bus.out_vld, vecs[i].exp_vld);
            repeat (19) @(posedge clk);
            #1;
            check8($sformatf("vec%0d_hold", i), bus.out, pin(vecs[i].exp_out));
        end

        // Back-to-back select changes; also confirm no input-to-output path
        // by looking at out right after the inputs move.
        step(1'b1, 3'b000);
        check8("lat_000", bus.out, pin(8'h01));
        @(negedge clk);
        {bus.a, bus.b, bus.c} = 3'b111;
        #1;
        check8("no_comb_path", bus.out, pin(8'h01));
        @(posedge clk);
        #1;
        check8("lat_111", bus.out, pin(8'h80));
        step(1'b1, 3'b010);
        check8("lat_010", bus.out, pin(8'h04));

        // Asynchronous reset between edges while out=80.
        step(1'b1, 3'b111);
        check8("pre_async_out", bus.out, pin(8'h80));
        #2;
        rst_n = 1'b0;
        #1;
        check8("async_rst_out", bus.out, pin(c_idle));
        check1("async_rst_vld", bus.out_vld, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'b110);
        check8("resume_out", bus.out, pin(8'h40));

        // Random stimulus against an arithmetic model: code = 2**sel.
        for (int n = 0; n < 300; n++) begin
            r_en  = ($urandom_range(0, 3) != 0);
            r_sel = 3'($urandom_range(0, 7));
            step(r_en, r_sel);
            exp_code = r_en ? 8'(2 ** int'(r_sel)) : c_idle;
            check8("rand_out", bus.out, pin(exp_code));
            check1("rand_vld", bus.out_vld, r_en);
            if (bus.out_vld === 1'b1) begin
                checks++;
                if ($countones(pin(bus.out)) != 1) begin
                    failures++;
                    $display("FAIL rand_onehot: out=%h has %0d active lines", bus.out,
                             $countones(pin(bus.out)));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_decoder3_to_8
`default_nettype wire
